// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one down-counting timer among N requesters.
// Optional: define TIMER_ARBITER_CANCEL_EN to abandon a count when the owner drops req.
module timer_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] value,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q,  last_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    int            scan_idx;

    // Scan from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        scan_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            scan_idx = (int'(last_q) + k) % N;
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_RUN;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    count_d = value[pick_idx*W +: W];
                end
            end
            ST_RUN: begin
`ifdef TIMER_ARBITER_CANCEL_EN
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                end else
`endif
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode registered state only; req/value never reach them directly.
    always_comb begin
        grant = '0;
        done  = '0;
        busy  = (state_q != ST_IDLE);
        if (state_q == ST_RUN) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == ST_DONE) begin
            done[owner_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: transaction-level model plus directed scenarios.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] value = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model: a service is "active" from its winning edge; phase counts cycles since then.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_last   = N - 1;
    int m_len    = 0;
    int m_p      = 0;

    always #5 clock = ~clock;

    timer_arbiter #(.N(N), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .value (value),
        .grant (grant),
        .done  (done),
        .busy  (busy)
    );

    function automatic int rrWinner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int idxOf(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    function automatic int valueOf(input int i);
        return int'(value[i*W +: W]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_active <= 1'b0;
            m_owner  <= 0;
            m_last   <= N - 1;
            m_len    <= 0;
            m_p      <= 0;
        end else if (m_active) begin
            if (m_p == m_len) m_active <= 1'b0;
`ifdef TIMER_ARBITER_CANCEL_EN
            else if (!req[m_owner]) m_active <= 1'b0;
`endif
            else m_p <= m_p + 1;
        end else if (rrWinner(req, m_last) >= 0) begin
            m_owner  <= rrWinner(req, m_last);
            m_last   <= rrWinner(req, m_last);
            m_len    <= valueOf(rrWinner(req, m_last)) + 1;
            m_p      <= 0;
            m_active <= 1'b1;
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        if (check_en) begin
            eg = '0;
            ed = '0;
            if (m_active && m_p < m_len) eg[m_owner] = 1'b1;
            if (m_active && m_p == m_len) ed[m_owner] = 1'b1;
            checkOutput("model_grant", 32'(grant), 32'(eg));
            checkOutput("model_done",  32'(done),  32'(ed));
            checkOutput("model_busy",  32'(busy),  32'(m_active));
        end
    end

    task automatic applyReset();
        @(posedge clock); #2;
        reset = 1'b1;
        req   = '0;
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (!busy) break;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic runSingle(input int who, input int v, input int exp_len, input string tag);
        int gc = 0;
        int dc = 0;
        bit seen = 1'b0;
        logic [N-1:0] mask;
        mask = '0;
        mask[who] = 1'b1;
        @(posedge clock); #2;
        value[who*W +: W] = W'(v);
        req = mask;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clock);
            if (grant == mask) gc++;
            if (done == mask) begin
                dc++;
                seen = 1'b1;
                req  = '0;
            end
        end
        @(negedge clock);
        checkOutput({tag, "_grant_len"}, 32'(gc), 32'(exp_len));
        checkOutput({tag, "_done_cnt"},  32'(dc), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic runRoundRobin();
        int order[$];
        int glen[$];
        int done_t[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int run = 0;
        logic [N-1:0] prev = '0;
        @(posedge clock); #2;
        for (int i = 0; i < N; i++) value[i*W +: W] = W'(2);
        req = '1;
        for (int c = 0; c < 60 && done_t.size() < 5; c++) begin
            @(negedge clock);
            if (grant != '0 && prev == '0) order.push_back(idxOf(grant));
            if (grant != '0) run++;
            else if (prev != '0) begin
                glen.push_back(run);
                run = 0;
            end
            if (done != '0) done_t.push_back(c);
            prev = grant;
        end
        req = '0;
        checkOutput("rr_grants", 32'(order.size()), 32'd5);
        checkOutput("rr_dones",  32'(done_t.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            checkOutput("rr_order", 32'(order[i]), 32'(exp_order[i]));
        for (int i = 0; i < glen.size(); i++)
            checkOutput("rr_grant_len", 32'(glen[i]), 32'd3);
        for (int i = 1; i < done_t.size(); i++)
            checkOutput("rr_done_gap", 32'(done_t[i] - done_t[i-1]), 32'd5);
        waitIdle("rr");
    endtask

    task automatic runCancel();
        int g1 = 0;
        int d1 = 0;
        int gap = 0;
        bit dropped = 1'b0;
        bit saw2 = 1'b0;
        @(posedge clock); #2;
        value = '0;
        value[1*W +: W] = W'(10);
        value[2*W +: W] = W'(1);
        req = 4'b0110;
        for (int c = 0; c < 60 && !saw2; c++) begin
            @(negedge clock);
            if (grant == 4'b0010) g1++;
            if (done == 4'b0010) d1++;
            if (g1 > 0 && grant == '0) gap++;
            if (grant == 4'b0100) saw2 = 1'b1;
            if (g1 == 3 && !dropped) begin
                req[1]  = 1'b0;
                dropped = 1'b1;
            end
        end
        req = '0;
        checkOutput("cancel_next_is_2", 32'(saw2), 32'd1);
`ifdef TIMER_ARBITER_CANCEL_EN
        checkOutput("cancel_grant1_len", 32'(g1), 32'd3);
        checkOutput("cancel_done1_cnt",  32'(d1), 32'd0);
        checkOutput("cancel_gap",        32'(gap), 32'd1);
`else
        checkOutput("cancel_grant1_len", 32'(g1), 32'd11);
        checkOutput("cancel_done1_cnt",  32'(d1), 32'd1);
        checkOutput("cancel_gap",        32'(gap), 32'd2);
`endif
        waitIdle("cancel");
    endtask

    task automatic runResetMidRun();
        bit got = 1'b0;
        @(posedge clock); #2;
        value = '0;
        value[2*W +: W] = W'(20);
        req = 4'b0100;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clock);
            if (grant == 4'b0100) got = 1'b1;
        end
        checkOutput("rst_mid_granted", 32'(got), 32'd1);
        repeat (3) @(negedge clock);
        @(posedge clock); #2;
        reset = 1'b1;
        req   = 4'b1111;
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_mid_grant", 32'(grant), 32'd0);
        checkOutput("rst_mid_done",  32'(done),  32'd0);
        checkOutput("rst_mid_busy",  32'(busy),  32'd0);
        @(negedge clock);
        checkOutput("rst_mid_winner0", 32'(grant), 32'd1);
        req = '0;
        waitIdle("rst_mid");
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock); #2;
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++) value[i*W +: W] = W'($urandom_range(0, 6));
        end
        @(posedge clock); #2;
        reset = 1'b0;
        req   = '0;
        waitIdle("random");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        check_en = 1'b1;
        @(negedge clock);
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_done",  32'(done),  32'd0);
        checkOutput("reset_busy",  32'(busy),  32'd0);

        runSingle(0, 5, 6, "v5");
        applyReset();
        runSingle(0, 0, 1, "v0");
        runSingle(0, 255, 256, "v255");
        runSingle(3, 4, 5, "r3v4");

        applyReset();
        runRoundRobin();

        applyReset();
        runCancel();

        applyReset();
        runResetMidRun();

        applyReset();
        applyStimulus(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
